// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the binary-to-BCD seven-segment display driver.
//   state_t     : conversion FSM states (IDLE, SHIFT, DONE)
//   SEG_BLANK   : active-low pattern with every segment dark
//   SEG_TABLE   : active-low glyphs for BCD 0..9, bit k = segment k (a..g)
//   min_digits  : smallest number of decimal digits that holds 2^width-1
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Smallest n with 10^n > 2^width - 1. Exact up to width 60; beyond that a
  // log10(2) approximation is used since 64-bit arithmetic would overflow.
  function automatic int unsigned min_digits(int unsigned width);
    longint unsigned lim;
    longint unsigned p;
    int unsigned     n;
    if (width > 60) begin
      return (width * 30103) / 100000 + 1;
    end
    lim = 64'd1 << width;
    p   = 64'd10;
    n   = 1;
    while (p < lim) begin
      p = p * 10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low seven-segment decoder.
//   digit : 4-bit BCD code; codes 10..15 decode to all segments dark
//   blank : 1 forces all segments dark
//   seg   : active-low segments, bit k = segment k (a..g)
module seg7_dec
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/bin2bcd_seg.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock)
// driving DIGITS active-low seven-segment displays.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   start  : request conversion of bin, honoured only when idle
//   bin    : WIDTH-bit unsigned value, captured on the accepting edge
//   busy   : high while bits are being shifted
//   done   : one-cycle pulse when bcd/hex take a new value
//   bcd    : DIGITS BCD digits, digit 0 (units) in [3:0]
//   hex    : DIGITS displays, display d in [7d+6:7d], active-low a..g
module bin2bcd_seg
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  if ((WIDTH < 1) || (DIGITS < min_digits(WIDTH))) begin : g_param_check
    $error("bin2bcd_seg: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_next;
  logic [BW-1:0]   bcd_r;
  logic            done_r;
  logic [DIGITS-1:0] blank;
  logic            zero_above;

  // Add-3 correction on every digit, then shift in the next binary bit.
  // The accumulator MSB falls off: it can never be set for in-range values.
  always_comb begin
    acc_adj = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_next = BW'({acc_adj, sreg[WIDTH-1]});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sreg   <= '0;
      acc    <= '0;
      bcd_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sreg  <= bin;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc  <= acc_next;
          sreg <= sreg << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_r  <= acc;
          done_r <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Leading-zero chain: display d is blanked when it and every higher digit
  // are zero. Display 0 is never blanked so a zero value still shows "0".
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned d = DIGITS - 1; d > 0; d--) begin
      zero_above = zero_above && (bcd_r[4*d +: 4] == 4'd0);
      blank[d]   = BLANK_LZ && zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .digit (bcd_r[4*g +: 4]),
      .blank (blank[g]),
      .seg   (hex[7*g +: 7])
    );
  end

  assign busy = (state == ST_SHIFT);
  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: tb/tb_bin2bcd_seg.sv
// Scoreboard bench for bin2bcd_seg: three instances (8-bit with and without
// leading-zero blanking sharing stimulus, and a 4-bit two-digit variant).
module tb_bin2bcd_seg;

  typedef struct {
    int  v;
    time t;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [7:0]  bin;
  logic        start_c;
  logic [3:0]  bin_c;

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [11:0] bcd_a, bcd_b;
  logic [20:0] hex_a, hex_b;
  logic [7:0]  bcd_c;
  logic [13:0] hex_c;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int total = 0;
  int bad   = 0;

  bin2bcd_seg #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .hex(hex_a)
  );

  bin2bcd_seg #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .hex(hex_b)
  );

  bin2bcd_seg #(.WIDTH(4), .DIGITS(2), .BLANK_LZ(1'b1)) dut_c (
    .clk(clk), .resetn(resetn), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .hex(hex_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal digits by division, glyphs from the segment
  // lists of each numeral, blanking by comparing the value with 10^d.
  function automatic logic [6:0] glyph(int n);
    logic [6:0] on; // active-high, bit k = segment a..g
    case (n)
      0: on = 7'b0111111;
      1: on = 7'b0000110;
      2: on = 7'b1011011;
      3: on = 7'b1001111;
      4: on = 7'b1100110;
      5: on = 7'b1101101;
      6: on = 7'b1111101;
      7: on = 7'b0000111;
      8: on = 7'b1111111;
      9: on = 7'b1101111;
      default: on = 7'b0000000;
    endcase
    return ~on;
  endfunction

  function automatic logic [63:0] ref_bcd(int v, int nd);
    logic [63:0] r = '0;
    int p = 1;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_hex(int v, int nd, bit blz);
    logic [63:0] r = '0;
    int p = 1;
    for (int d = 0; d < nd; d++) begin
      if (blz && d > 0 && v < p) r[7*d +: 7] = 7'h7F;
      else                       r[7*d +: 7] = glyph((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop an expectation whenever a done pulse is seen.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a) begin
      if (qa.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_bcd", 64'(bcd_a), ref_bcd(e.v, 3));
        check("a_hex", 64'(hex_a), ref_hex(e.v, 3, 1'b1));
        check("a_latency", 64'($time - e.t), 64'd95);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b) begin
      if (qb.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_bcd", 64'(bcd_b), ref_bcd(e.v, 3));
        check("b_hex", 64'(hex_b), ref_hex(e.v, 3, 1'b0));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (done_c) begin
      if (qc.size() == 0) check("c_unexpected_done", 1, 0);
      else begin
        e = qc.pop_front();
        check("c_bcd", 64'(bcd_c), ref_bcd(e.v, 2));
        check("c_hex", 64'(hex_c), ref_hex(e.v, 2, 1'b1));
        check("c_latency", 64'($time - e.t), 64'd55);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue_ab(int v, bit push);
    start = 1'b1;
    bin   = 8'(v);
    @(posedge clk);
    if (push) begin
      qa.push_back('{v, $time});
      qb.push_back('{v, $time});
    end
    @(negedge clk);
    start = 1'b0;
    bin   = 8'($urandom);
    check("a_busy_after_accept", 64'(busy_a), 64'd1);
  endtask

  task automatic issue_c(int v);
    start_c = 1'b1;
    bin_c   = 4'(v);
    @(posedge clk);
    qc.push_back('{v, $time});
    @(negedge clk);
    start_c = 1'b0;
    bin_c   = 4'($urandom);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 40; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(negedge clk);
    end
    check(name, 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_done"}, 64'({done_a, done_b, done_c}), 64'd0);
    check({tag, "_busy"}, 64'({busy_a, busy_b, busy_c}), 64'd0);
    check({tag, "_bcd"},  64'({bcd_a, bcd_b, bcd_c}), 64'd0);
    check({tag, "_hex_a"}, 64'(hex_a), ref_hex(0, 3, 1'b1));
    check({tag, "_hex_b"}, 64'(hex_b), ref_hex(0, 3, 1'b0));
    check({tag, "_hex_c"}, 64'(hex_c), ref_hex(0, 2, 1'b1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : stim
    resetn  = 1'b0;
    start   = 1'b0;
    bin     = '0;
    start_c = 1'b0;
    bin_c   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Directed values: max, zero, single digit.
    issue_ab(255, 1'b1); drain("drain_255");
    issue_ab(0, 1'b1);   drain("drain_0");
    issue_ab(7, 1'b1);   drain("drain_7");

    // Start pulse during SHIFT must be ignored.
    issue_ab(200, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    drain("drain_ignored_start");
    repeat (15) @(negedge clk);

    // Randomised values.
    for (int i = 0; i < 20; i++) begin
      issue_ab(int'($urandom_range(0, 255)), 1'b1);
      drain("drain_random");
    end

    // Reset in the middle of a conversion: no done may follow.
    issue_ab(99, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (12) @(negedge clk);
    resetn = 1'b1;
    issue_ab(42, 1'b1);
    drain("drain_after_abort");

    // Four-bit variant sweep.
    for (int v = 0; v < 16; v++) begin
      issue_c(v);
      drain("drain_c");
    end

    // Exhaustive back-to-back sweep with start held high: one accept every
    // 10 cycles, bin switched just after each capture.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd0;
    for (int v = 0; v < 256; v++) begin
      @(posedge clk);
      qa.push_back('{v, $time});
      qb.push_back('{v, $time});
      @(negedge clk);
      if (v == 255) start = 1'b0;
      else          bin   = 8'(v + 1);
      repeat (9) @(posedge clk);
    end
    @(negedge clk);
    drain("drain_sweep");
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seg.md
# bin2bcd_seg

Parametrised sequential binary-to-decimal display driver, the successor of the 4-bit two-digit switch decoder. It converts a WIDTH-bit unsigned value to DIGITS BCD digits with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It registers the result and drives DIGITS active-low seven-segment displays, with optional leading-zero blanking. It sits between any binary producer (switches, counters, ALU results) and the board HEX displays.

## Interface
Parameters:
- WIDTH, 8: binary input width, ≥1.
- DIGITS, 3: BCD digits / displays driven. Elaboration error unless 10^DIGITS > 2^WIDTH − 1.
- BLANK_LZ, 1: 1 = blank leading zero digits (digit 0 always shown); 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of bin; sampled only in IDLE.
- bin  in  WIDTH  unsigned value, captured on the accepting edge.
- busy  out  1  high while a conversion is in progress (SHIFT state).
- done  out  1  one-cycle pulse when bcd/hex update.
- bcd  out  4*DIGITS  result; digit d at [4d+3:4d], digit 0 = units.
- hex  out  7*DIGITS  display d at [7d+6:7d]; bit 7d+k drives segment k (k=0..6 = a..g); active-low.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, load shift register with bin, clear BCD accumulator, load bit counter with WIDTH, go to SHIFT. start=0: stay.
- SHIFT, once per cycle: every accumulator digit ≥5 gets +3, then {accumulator, shift register} shifts left by 1 (shift-register MSB enters accumulator bit 0); counter decrements. After the WIDTH-th shift, go to DONE.
- DONE: copy accumulator to bcd, recompute hex, assert done for this cycle, return to IDLE.
- start during SHIFT or DONE is ignored (not queued); bin changes after capture have no effect.
- bcd and hex hold last result between conversions.
- Decode: BCD 0–9 → standard seven-segment glyphs (0: a–f lit, g dark; 1: b,c lit; 7: a,b,c lit). Codes 10–15 cannot occur; decode them to blank (all segments 1).
- Blanking (BLANK_LZ=1): display d>0 blanked when digits d..DIGITS−1 are all zero. Zero value shows a single "0" on display 0.
- Registered outputs only; no combinational path from start/bin to any output.

## Timing
- Start accepted on edge T0; busy high T0+1..T0+WIDTH; done high and bcd/hex valid from edge T0+WIDTH+1. Latency WIDTH+1 cycles.
- Throughput: next start accepted at edge T0+WIDTH+2 at earliest (one conversion per WIDTH+2 cycles).
- Reset (any time, including mid-conversion): state=IDLE, busy=0, done=0, bcd=0, counter=0. hex shows "0" on display 0; other displays are blank if BLANK_LZ=1, otherwise "0". An aborted conversion never produces done.
- Reset release: first start is accepted on the first rising edge with resetn=1.

## Structure
- Package bin2bcd_pkg: state enum (IDLE, SHIFT, DONE); SEG_BLANK = 7'h7F; the 10-entry active-low segment constant table; function computing minimum DIGITS for a WIDTH (used in the parameter check).
- Sub-module seg7_dec: 4-bit BCD plus blank input → 7-bit active-low segments. Purely combinational; instantiated DIGITS times on the registered bcd.
- Top holds the FSM, counter (clog2(WIDTH+1) bits), shift/accumulator register, add-3 correction array and leading-zero chain.

## Test plan
- WIDTH=8, DIGITS=3: start with bin=255 → done exactly 9 cycles later; bcd=12'h255; displays 2,5,5.
- bin=0, BLANK_LZ=1 → bcd=0; displays 2 and 1 = 7'h7F; display 0 = "0". Same with BLANK_LZ=0 → "000". bin=7, BLANK_LZ=1 → blank, blank, "7".
- Start at T0 with bin=200; pulse start with bin=5 at T0+3 → single done; bcd=12'h200; no second done.
- Deassert resetn at T0+4 of a conversion → outputs immediately at reset values, no done; new start after release with bin=42 → bcd=12'h042.
- WIDTH=4, DIGITS=2: sweep 0–15 → bcd 00–15 (e.g. 12 → displays "1","2"; 9 → blank,"9"). Matches the 4-bit switch decoder.
- Exhaustive WIDTH=8 sweep 0–255 back-to-back with start held high: every done carries correct bcd/hex versus reference model; done spacing 10 cycles.
